// File: rtl/prescaler.sv
// Clock-enable prescaler: emits a one-cycle CEO pulse on every divide_factor-th qualified CE cycle.
// Optional build macro PRESCALER_CNT_OUT_EN exposes the internal counter on port CNT.
module prescaler #(
  parameter int divide_factor = 15,
  localparam int CNT_W = (divide_factor > 1) ? $clog2(divide_factor) : 1
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             CE,
  output logic             CEO
`ifdef PRESCALER_CNT_OUT_EN
  ,
  output logic [CNT_W-1:0] CNT
`endif
);

  if (divide_factor < 1) begin : g_bad_factor
    $error("prescaler: divide_factor must be at least 1");
  end

  // Terminal value sized to the counter; divide_factor-1 always fits in CNT_W bits.
  localparam logic [CNT_W-1:0] TERM = CNT_W'(divide_factor - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_term;

  always_comb begin
    at_term = (cnt_q == TERM);
    cnt_d   = cnt_q;
    if (CE) begin
      cnt_d = at_term ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Unregistered so cascaded stages see zero latency; CLR gates it during reset.
  assign CEO = CLR & CE & at_term;

`ifdef PRESCALER_CNT_OUT_EN
  assign CNT = cnt_q;
`endif

endmodule

// File: tb/tb_prescaler.sv
// Scoreboard bench for prescaler: N=15, N=1 and N=4 instances share one stimulus stream.
`timescale 1ns/1ps
module tb_prescaler;

  typedef struct packed {
    logic       ceo15;
    logic       ceo1;
    logic       ceo4;
    logic [3:0] cnt15;
    logic [1:0] cnt4;
  } exp_t;

  logic clk;
  logic clr;
  logic ce;
  logic ceo15, ceo1, ceo4;
  logic [3:0] cnt15;
  logic [0:0] cnt1;
  logic [1:0] cnt4;

  exp_t   sb[$];
  longint pulse_t[$];
  int     n_pass  = 0;
  int     n_total = 0;
  int     m15 = 0;
  int     m4  = 0;
  longint rel_t;

  prescaler #(.divide_factor(15)) u15 (
    .CLK(clk), .CLR(clr), .CE(ce), .CEO(ceo15)
`ifdef PRESCALER_CNT_OUT_EN
    , .CNT(cnt15)
`endif
  );
  prescaler #(.divide_factor(1)) u1 (
    .CLK(clk), .CLR(clr), .CE(ce), .CEO(ceo1)
`ifdef PRESCALER_CNT_OUT_EN
    , .CNT(cnt1)
`endif
  );
  prescaler #(.divide_factor(4)) u4 (
    .CLK(clk), .CLR(clr), .CE(ce), .CEO(ceo4)
`ifdef PRESCALER_CNT_OUT_EN
    , .CNT(cnt4)
`endif
  );

`ifndef PRESCALER_CNT_OUT_EN
  assign cnt15 = '0;
  assign cnt1  = '0;
  assign cnt4  = '0;
`endif

  initial begin
    clk = 1'b0;
    forever #4 clk = ~clk;
  end

  function automatic void check(input string name, input longint act, input longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
  endfunction

  // One clock cycle: the model advances on the edge, then new inputs go on 1 ns later.
  task automatic step(input logic ce_v, input logic clr_v);
    exp_t e;
    @(posedge clk);
    if (clr && ce) begin
      m15 = (m15 == 14) ? 0 : m15 + 1;
      m4  = (m4 == 3) ? 0 : m4 + 1;
    end
    #1;
    ce  = ce_v;
    clr = clr_v;
    if (!clr) begin
      m15 = 0;
      m4  = 0;
    end
    e.ceo15 = clr & ce & (m15 == 14);
    e.ceo1  = clr & ce;
    e.ceo4  = clr & ce & (m4 == 3);
    e.cnt15 = 4'(m15);
    e.cnt4  = 2'(m4);
    sb.push_back(e);
  endtask

  // Monitor: every cycle the outputs are valid; compare mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("ceo_n15", longint'(ceo15), longint'(e.ceo15));
      check("ceo_n1",  longint'(ceo1),  longint'(e.ceo1));
      check("ceo_n4",  longint'(ceo4),  longint'(e.ceo4));
`ifdef PRESCALER_CNT_OUT_EN
      check("cnt_n15", longint'(cnt15), longint'(e.cnt15));
      check("cnt_n4",  longint'(cnt4),  longint'(e.cnt4));
      if (cnt4 == 2'd3 || ceo4) check("ceo_n4_at_cnt3", longint'(ceo4), longint'(ce));
`endif
      if (ceo15) pulse_t.push_back($time);
    end
  end

  initial begin
    ce  = 1'b0;
    clr = 1'bx;
    #0 clr = 1'b0;

    // Reset with CE high: everything held at zero.
    repeat (3) step(1'b1, 1'b0);

    // Free run for 400 ns: pulses after 14 edges, then every 120 ns.
    pulse_t.delete();
    step(1'b1, 1'b1);
    rel_t = $time;
    repeat (49) step(1'b1, 1'b1);
    @(negedge clk); #1;
    check("run_pulse_count", pulse_t.size(), 3);
    check("run_first_pulse_ns", (pulse_t.size() > 0) ? pulse_t[0] - rel_t : -1, 115);
    check("run_spacing1_ns", (pulse_t.size() > 1) ? pulse_t[1] - pulse_t[0] : -1, 120);
    check("run_spacing2_ns", (pulse_t.size() > 2) ? pulse_t[2] - pulse_t[1] : -1, 120);

    // Asynchronous clear while cnt=7, then a full 14-edge restart.
    while (m15 != 7) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    pulse_t.delete();
    step(1'b1, 1'b1);
    rel_t = $time;
    repeat (14) step(1'b1, 1'b1);
    @(negedge clk); #1;
    check("restart_pulse_count", pulse_t.size(), 1);
    check("restart_first_pulse_ns", (pulse_t.size() > 0) ? pulse_t[0] - rel_t : -1, 115);

    // Reset arriving in the terminal cycle suppresses the pulse.
    while (m15 != 14) step(1'b1, 1'b1);
    step(1'b1, 1'b0);

    // CE held low for 20 cycles after reset.
    step(1'b0, 1'b1);
    repeat (19) step(1'b0, 1'b1);

    // Alternating CE: pulses 30 cycles apart, only when CE=1.
    step(1'b1, 1'b0);
    pulse_t.delete();
    for (int i = 0; i < 60; i++) step((i % 2) == 0, 1'b1);
    @(negedge clk); #1;
    check("alt_pulse_count", pulse_t.size(), 2);
    check("alt_spacing_ns", (pulse_t.size() > 1) ? pulse_t[1] - pulse_t[0] : -1, 240);

    // CE dropping at terminal count: pulse drops, count holds, then resumes.
    while (m15 != 14) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (5) step(1'b1, 1'b1);

    repeat (3) @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
